uart_tx_serializer: RTL and testbench

//  Downstream consumer of the dual-clock byte FIFO, in the tx_clock domain.

---
 rtl/uart_pkg.sv | 30 +++
 rtl/uart_tx_serializer_if.sv | 11 +
 rtl/uart_baud_tick.sv | 38 +++
 rtl/uart_tx_serializer.sv | 141 ++++++++++++++
 tb/tb_uart_tx_serializer.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART path. The transmitter uses them now,
// and a future receiver will use them too.
package uart_pkg;

  localparam int   DEFAULT_CLKS_PER_BIT = 16;
  localparam int   DEFAULT_DATA_BITS    = 8;
  localparam int   BIT_CNT_W            = 3;
  localparam logic IDLE_LEVEL           = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_POP,
    ST_LOAD,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_e;

  // Even parity over the low nbits of a byte; higher bits are ignored.
  function automatic logic even_parity(input logic [7:0] data, input int nbits);
    logic p;
    p = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i < nbits) p = p ^ data[i[2:0]];
    end
    return p;
  endfunction

endpackage

// File: rtl/uart_tx_serializer_if.sv
// Read side of the dual-clock byte FIFO, seen from the tx_clock domain.
interface uart_tx_serializer_if;

  logic       fifo_empty;
  logic [7:0] fifo_data;
  logic       fifo_pop;

  modport master (output fifo_empty, output fifo_data, input fifo_pop);
  modport slave  (input fifo_empty, input fifo_data, output fifo_pop);

endinterface

// File: rtl/uart_baud_tick.sv
// Bit-period counter. It runs 0..CLKS_PER_BIT-1 while enabled and ticks on the
// wrap cycle. The count is exposed so that a receiver can find mid-bit.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  localparam int CNT_W       = $clog2(CLKS_PER_BIT)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             clr_i,
  output logic             tick_o,
  output logic [CNT_W-1:0] count_o
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] count_q, count_d;

  assign tick_o  = en_i && (count_q == LAST);
  assign count_o = count_q;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = tick_o ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

endmodule

// File: rtl/uart_tx_serializer.sv
// This module pops bytes from the FIFO and sends each one LSB-first as an
// asynchronous UART frame. All outputs are registered.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int DATA_BITS    = DEFAULT_DATA_BITS,
  parameter int PARITY_EN    = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 tx_clock,
  input  logic                 reset_n,
  uart_tx_serializer_if.slave  fifo,
  output logic                 serial_out,
  output logic                 busy,
  output logic                 frame_done
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]     PRE_LAST  = CNT_W'(CLKS_PER_BIT - 2);
  localparam logic [BIT_CNT_W-1:0] LAST_DATA = BIT_CNT_W'(DATA_BITS - 1);
  localparam logic [BIT_CNT_W-1:0] LAST_STOP = BIT_CNT_W'(STOP_BITS - 1);

  tx_state_e            state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic                 parity_q, parity_d;
  logic                 serial_q, serial_d;
  logic                 pop_q, pop_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 baud_en, baud_clr, baud_tick;
  logic [CNT_W-1:0]     baud_cnt;

  uart_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk     (tx_clock),
    .rst_n   (reset_n),
    .en_i    (baud_en),
    .clr_i   (baud_clr),
    .tick_o  (baud_tick),
    .count_o (baud_cnt)
  );

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    parity_d  = parity_q;
    baud_en   = 1'b0;
    baud_clr  = 1'b1;

    case (state_q)
      ST_IDLE: if (!fifo.fifo_empty) state_d = ST_POP;
      ST_POP:  state_d = ST_LOAD;
      ST_LOAD: begin
        shift_d   = fifo.fifo_data[DATA_BITS-1:0];
        parity_d  = even_parity(fifo.fifo_data, DATA_BITS);
        bit_cnt_d = '0;
        state_d   = ST_START;
      end
      ST_START: begin
        baud_en  = 1'b1;
        baud_clr = 1'b0;
        if (baud_tick) state_d = ST_DATA;
      end
      ST_DATA: begin
        baud_en  = 1'b1;
        baud_clr = 1'b0;
        if (baud_tick) begin
          if (bit_cnt_q == LAST_DATA) begin
            bit_cnt_d = '0;
            if (PARITY_EN != 0) state_d = ST_PARITY;
            else                state_d = ST_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            shift_d   = shift_q >> 1;
          end
        end
      end
      ST_PARITY: begin
        baud_en  = 1'b1;
        baud_clr = 1'b0;
        if (baud_tick) state_d = ST_STOP;
      end
      ST_STOP: begin
        baud_en  = 1'b1;
        baud_clr = 1'b0;
        if (baud_tick) begin
          if (bit_cnt_q == LAST_STOP) begin
            bit_cnt_d = '0;
            state_d   = fifo.fifo_empty ? ST_IDLE : ST_POP;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Registered outputs are derived from the next state, so they line up with state_q.
    pop_d  = (state_d == ST_POP);
    busy_d = (state_d != ST_IDLE);
    done_d = (state_q == ST_STOP) && (state_d == ST_STOP) &&
             (bit_cnt_q == LAST_STOP) && (baud_cnt == PRE_LAST);

    case (state_d)
      ST_START:  serial_d = ~IDLE_LEVEL;
      ST_DATA:   serial_d = shift_d[0];
      ST_PARITY: serial_d = parity_d;
      default:   serial_d = IDLE_LEVEL;
    endcase
  end

  always_ff @(posedge tx_clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      parity_q  <= 1'b0;
      serial_q  <= IDLE_LEVEL;
      pop_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      parity_q  <= parity_d;
      serial_q  <= serial_d;
      pop_q     <= pop_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign fifo.fifo_pop = pop_q;
  assign serial_out    = serial_q;
  assign busy          = busy_q;
  assign frame_done    = done_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for three serializer configurations: 8N1, 8E1 and 7N2, each at 4 clocks per bit.
// Each configuration has its own FIFO model, and every frame is compared bit by bit against hand-built frames.
module tb_uart_tx_serializer;

  localparam int CPB = 4;

  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  uart_tx_serializer_if ifA ();
  uart_tx_serializer_if ifB ();
  uart_tx_serializer_if ifC ();

  logic serA, serB, serC, busyA, busyB, busyC, doneA, doneB, doneC;
  logic [2:0] serV, busyV, doneV, popV;

  assign serV  = {serC, serB, serA};
  assign busyV = {busyC, busyB, busyA};
  assign doneV = {doneC, doneB, doneA};
  assign popV  = {ifC.fifo_pop, ifB.fifo_pop, ifA.fifo_pop};

  uart_tx_serializer #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(0), .STOP_BITS(1)) dutA (
    .tx_clock(clock), .reset_n(reset_n), .fifo(ifA),
    .serial_out(serA), .busy(busyA), .frame_done(doneA));

  uart_tx_serializer #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(1), .STOP_BITS(1)) dutB (
    .tx_clock(clock), .reset_n(reset_n), .fifo(ifB),
    .serial_out(serB), .busy(busyB), .frame_done(doneB));

  uart_tx_serializer #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY_EN(0), .STOP_BITS(2)) dutC (
    .tx_clock(clock), .reset_n(reset_n), .fifo(ifC),
    .serial_out(serC), .busy(busyC), .frame_done(doneC));

  logic [7:0] qA[$];
  logic [7:0] qB[$];
  logic [7:0] qC[$];
  int popCnt[3] = '{0, 0, 0};

  int vectorsApplied = 0;
  int miscompares = 0;

  // The FIFO model presents the head byte after a pop and derives its empty flag from the queue depth.
  always @(negedge clock) begin
    if (ifA.fifo_pop && qA.size() > 0) ifA.fifo_data = qA.pop_front();
    if (ifB.fifo_pop && qB.size() > 0) ifB.fifo_data = qB.pop_front();
    if (ifC.fifo_pop && qC.size() > 0) ifC.fifo_data = qC.pop_front();
    ifA.fifo_empty = (qA.size() == 0);
    ifB.fifo_empty = (qB.size() == 0);
    ifC.fifo_empty = (qC.size() == 0);
    for (int d = 0; d < 3; d++) if (popV[d] === 1'b1) popCnt[d]++;
  end

  typedef struct {
    int         dut;
    logic [7:0] data;
    logic [11:0] frame;
    int         nbits;
    string      name;
  } vec_t;

  vec_t vecs[6];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectorsApplied++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input int d, input logic [7:0] data);
    case (d)
      0:       qA.push_back(data);
      1:       qB.push_back(data);
      default: qC.push_back(data);
    endcase
  endtask

  // Waits for the pop and checks the 2-cycle idle gap. It then checks every cycle of the frame, and frame_done on its last cycle.
  task automatic expectFrame(input int d, input logic [11:0] frame, input int nbits,
                             input int maxWait, input string name, output int waited);
    int   w;
    bit   got;
    int   doneCnt, doneAt, busyBad, popBad;
    logic sample;
    got = 1'b0;
    w = 0;
    while (!got && w < maxWait) begin
      @(negedge clock);
      w++;
      if (popV[d] === 1'b1) got = 1'b1;
    end
    waited = w;
    checkOutput({name, " pop_seen"}, 32'(got), 32'd1);
    if (!got) return;
    checkOutput({name, " pop_line_idle"}, 32'(serV[d]), 32'd1);
    @(negedge clock);
    checkOutput({name, " load_no_second_pop"}, 32'(popV[d]), 32'd0);
    checkOutput({name, " load_line_idle"}, 32'(serV[d]), 32'd1);
    doneCnt = 0;
    doneAt = -1;
    busyBad = 0;
    popBad = 0;
    for (int b = 0; b < nbits; b++) begin
      sample = frame[b];
      for (int c = 0; c < CPB; c++) begin
        @(negedge clock);
        if (serV[d] !== frame[b]) sample = serV[d];
        if (busyV[d] !== 1'b1) busyBad++;
        if (popV[d] !== 1'b0) popBad++;
        if (doneV[d] === 1'b1) begin
          doneCnt++;
          doneAt = b * CPB + c;
        end
      end
      checkOutput($sformatf("%s bit%0d", name, b), 32'(sample), 32'(frame[b]));
    end
    checkOutput({name, " done_count"}, 32'(doneCnt), 32'd1);
    checkOutput({name, " done_cycle"}, 32'(doneAt), 32'(nbits * CPB - 1));
    checkOutput({name, " busy_low_cycles"}, 32'(busyBad), 32'd0);
    checkOutput({name, " pops_in_frame"}, 32'(popBad), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base, waited, bad, got;
    reset_n = 1'b0;

    // Frames are listed in transmit order from bit 0: start, data LSB-first, parity, then stop bit(s).
    vecs[0] = '{0, 8'hA5, 12'h34A, 10, "A_8N1_A5"};
    vecs[1] = '{1, 8'h07, 12'h60E, 11, "B_8E1_07"};
    vecs[2] = '{1, 8'h03, 12'h406, 11, "B_8E1_03"};
    vecs[3] = '{1, 8'hA5, 12'h54A, 11, "B_8E1_A5"};
    vecs[4] = '{2, 8'h3A, 12'h374, 10, "C_7N2_3A"};
    vecs[5] = '{2, 8'hC5, 12'h38A, 10, "C_7N2_C5"};

    bad = 0;
    repeat (10) begin
      @(negedge clock);
      if (serV !== 3'b111 || busyV !== 3'b000 || popV !== 3'b000 || doneV !== 3'b000) bad++;
    end
    checkOutput("in_reset_outputs_bad_cycles", 32'(bad), 32'd0);
    reset_n = 1'b1;
    bad = 0;
    repeat (100) begin
      @(negedge clock);
      if (serV !== 3'b111 || busyV !== 3'b000 || popV !== 3'b000 || doneV !== 3'b000) bad++;
    end
    checkOutput("idle_empty_bad_cycles", 32'(bad), 32'd0);
    checkOutput("idle_pop_total", 32'(popCnt[0] + popCnt[1] + popCnt[2]), 32'd0);

    for (int i = 0; i < 6; i++) begin
      base = popCnt[vecs[i].dut];
      @(posedge clock);
      #1;
      applyStimulus(vecs[i].dut, vecs[i].data);
      expectFrame(vecs[i].dut, vecs[i].frame, vecs[i].nbits, 20, vecs[i].name, waited);
      checkOutput({vecs[i].name, " pop_latency"}, 32'(waited), 32'd2);
      @(negedge clock);
      checkOutput({vecs[i].name, " busy_after"}, 32'(busyV[vecs[i].dut]), 32'd0);
      checkOutput({vecs[i].name, " line_after"}, 32'(serV[vecs[i].dut]), 32'd1);
      checkOutput({vecs[i].name, " pop_count"}, 32'(popCnt[vecs[i].dut] - base), 32'd1);
    end

    // Three queued bytes must go out back-to-back, with exactly two idle-high cycles between frames.
    base = popCnt[0];
    @(posedge clock);
    #1;
    applyStimulus(0, 8'h00);
    applyStimulus(0, 8'hFF);
    applyStimulus(0, 8'h3C);
    expectFrame(0, 12'h200, 10, 20, "b2b_00", waited);
    expectFrame(0, 12'h3FE, 10, 1, "b2b_FF", waited);
    expectFrame(0, 12'h278, 10, 1, "b2b_3C", waited);
    repeat (3) @(negedge clock);
    checkOutput("b2b busy_after", 32'(busyV[0]), 32'd0);
    checkOutput("b2b pop_count", 32'(popCnt[0] - base), 32'd3);

    // Reset during the data bits of 8'h55 abandons that frame, and the next byte then goes out cleanly.
    base = popCnt[0];
    @(posedge clock);
    #1;
    applyStimulus(0, 8'h55);
    got = 0;
    for (int w = 0; w < 20 && got == 0; w++) begin
      @(negedge clock);
      if (popV[0] === 1'b1) got = 1;
    end
    checkOutput("rst_mid pop_seen", 32'(got), 32'd1);
    repeat (11) @(negedge clock);
    checkOutput("rst_mid busy_before", 32'(busyV[0]), 32'd1);
    checkOutput("rst_mid data_bit1", 32'(serV[0]), 32'd0);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("rst_mid line_high", 32'(serV[0]), 32'd1);
    checkOutput("rst_mid busy_low", 32'(busyV[0]), 32'd0);
    checkOutput("rst_mid pop_low", 32'(popV[0]), 32'd0);
    applyStimulus(0, 8'h3C);
    bad = 0;
    repeat (4) begin
      @(negedge clock);
      if (popV[0] !== 1'b0 || serV[0] !== 1'b1) bad++;
    end
    checkOutput("rst_mid hold_bad_cycles", 32'(bad), 32'd0);
    reset_n = 1'b1;
    expectFrame(0, 12'h278, 10, 20, "post_reset_3C", waited);
    @(negedge clock);
    checkOutput("post_reset busy_after", 32'(busyV[0]), 32'd0);
    checkOutput("post_reset pop_count", 32'(popCnt[0] - base), 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
    $finish;
  end

endmodule
